// File: rtl/ctu_clsp_dramseq_pkg.sv
// Shared definitions for the DRAM-domain power-up / reset sequencer.
//   seq_state_e : sequencer state encodings (also exported on seq_state)
//   CH_*        : bit positions of the six clock-enable channels
//   CKEN_NUM    : number of clock-enable channels
package ctu_clsp_dramseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CKEN     = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_DEASSERT = 3'd3,
    ST_RUN      = 3'd4,
    ST_WRST     = 3'd5,
    ST_DBG      = 3'd6
  } seq_state_e;

  localparam int CKEN_NUM = 6;

  localparam logic [2:0] CH_DRAM02 = 3'd0;
  localparam logic [2:0] CH_DRAM13 = 3'd1;
  localparam logic [2:0] CH_DDR0   = 3'd2;
  localparam logic [2:0] CH_DDR1   = 3'd3;
  localparam logic [2:0] CH_DDR2   = 3'd4;
  localparam logic [2:0] CH_DDR3   = 3'd5;

endpackage

// File: rtl/ctu_clsp_dramseq_edgecnt.sv
// Loadable down-counter of DRAM sync-edge pulses.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load LOAD_VAL (takes priority over counting)
//   clr        : force the count to zero (highest priority)
//   en         : count sync_edge pulses only while high
//   sync_edge  : one-cycle sync-edge pulse
//   done       : combinational; high in the cycle the last expected pulse
//                arrives (enabled pulse with count == 1)
module ctu_clsp_dramseq_edgecnt #(
  parameter int unsigned LOAD_VAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  input  logic en,
  input  logic sync_edge,
  output logic done
);

  logic [3:0] cnt;

  // Saturates at zero; never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'(LOAD_VAL);
    end else if (en && sync_edge && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = en && sync_edge && (cnt == 4'd1);

endmodule

// File: rtl/ctu_clsp_dramseq.sv
// DRAM-domain power-up and reset sequencer for the CTU clock/reset interface.
// Staggers the six DRAM/DDR clock-enable requests, waits a number of sync
// edges, then opens the grst/dbginit deassert windows. In RUN it services
// warm-reset and debug-init requests (rising edges of level inputs).
//   dram_gclk, io_pwron_rst_l : clock, asynchronous active-low reset
//   start_clk_dg              : DRAM clocks may start; low forces IDLE
//   sync_edge_dg              : one-cycle pulse per DRAM/CMP sync edge
//   stagger_gap               : cycles between cken enables (0 acts as 1)
//   cken_mask                 : per-channel enable for cken_dg
//   wrm_rst_req_dg            : warm reset request (level, rising edge acts)
//   dbginit_req_dg            : debug-init request (level, rising edge acts)
//   cken_dg                   : clock-enable requests
//   a_grst_dg, a_dbginit_dg   : global reset / debug init assert levels
//   de_*_dsync_edge_dg        : deassert windows, held across one sync edge
//   seq_busy, seq_state       : not-in-RUN flag and state for debug
// All outputs are registered.
module ctu_clsp_dramseq
  import ctu_clsp_dramseq_pkg::*;
#(
  parameter int unsigned SETTLE_EDGES = 4,
  parameter int unsigned GAP_W        = 4
) (
  input  logic                dram_gclk,
  input  logic                io_pwron_rst_l,
  input  logic                start_clk_dg,
  input  logic                sync_edge_dg,
  input  logic [GAP_W-1:0]    stagger_gap,
  input  logic [CKEN_NUM-1:0] cken_mask,
  input  logic                wrm_rst_req_dg,
  input  logic                dbginit_req_dg,
  output logic [CKEN_NUM-1:0] cken_dg,
  output logic                a_grst_dg,
  output logic                a_dbginit_dg,
  output logic                de_grst_dsync_edge_dg,
  output logic                de_dbginit_dsync_edge_dg,
  output logic                seq_busy,
  output logic [2:0]          seq_state
);

  seq_state_e          state, state_n;
  logic [CKEN_NUM-1:0] cken_n;
  logic                agrst_n, adbg_n, degrst_n, dedbg_n, busy_n;
  logic [2:0]          ch_idx, ch_n;
  logic [GAP_W-1:0]    gap_cnt, gap_n, gap_load;
  logic                cold, cold_n;
  logic                armed, armed_n;     // DEASSERT: entry cycle has passed
  logic                dbg_win, dbg_win_n; // DBG: dbginit dropped, window open
  logic                wrm_q, dbg_q;
  logic                wrm_rise, dbg_rise;
  logic                ec_load, ec_clr, ec_en, ec_done;

  assign wrm_rise = wrm_rst_req_dg && !wrm_q;
  assign dbg_rise = dbginit_req_dg && !dbg_q;
  assign gap_load = (stagger_gap == '0) ? GAP_W'(1) : stagger_gap;

  ctu_clsp_dramseq_edgecnt #(.LOAD_VAL(SETTLE_EDGES)) u_edgecnt (
    .clk       (dram_gclk),
    .rst_n     (io_pwron_rst_l),
    .load      (ec_load),
    .clr       (ec_clr),
    .en        (ec_en),
    .sync_edge (sync_edge_dg),
    .done      (ec_done)
  );

  always_ff @(posedge dram_gclk or negedge io_pwron_rst_l) begin
    if (!io_pwron_rst_l) begin
      state                    <= ST_IDLE;
      cken_dg                  <= '0;
      a_grst_dg                <= 1'b1;
      a_dbginit_dg             <= 1'b1;
      de_grst_dsync_edge_dg    <= 1'b0;
      de_dbginit_dsync_edge_dg <= 1'b0;
      seq_busy                 <= 1'b1;
      ch_idx                   <= 3'd0;
      gap_cnt                  <= '0;
      cold                     <= 1'b0;
      armed                    <= 1'b0;
      dbg_win                  <= 1'b0;
      wrm_q                    <= 1'b0;
      dbg_q                    <= 1'b0;
    end else begin
      state                    <= state_n;
      cken_dg                  <= cken_n;
      a_grst_dg                <= agrst_n;
      a_dbginit_dg             <= adbg_n;
      de_grst_dsync_edge_dg    <= degrst_n;
      de_dbginit_dsync_edge_dg <= dedbg_n;
      seq_busy                 <= busy_n;
      ch_idx                   <= ch_n;
      gap_cnt                  <= gap_n;
      cold                     <= cold_n;
      armed                    <= armed_n;
      dbg_win                  <= dbg_win_n;
      wrm_q                    <= wrm_rst_req_dg;
      dbg_q                    <= dbginit_req_dg;
    end
  end

  always_comb begin
    state_n   = state;
    cken_n    = cken_dg;
    agrst_n   = a_grst_dg;
    adbg_n    = a_dbginit_dg;
    degrst_n  = de_grst_dsync_edge_dg;
    dedbg_n   = de_dbginit_dsync_edge_dg;
    ch_n      = ch_idx;
    gap_n     = gap_cnt;
    cold_n    = cold;
    armed_n   = armed;
    dbg_win_n = dbg_win;
    ec_load   = 1'b0;
    ec_clr    = 1'b0;
    ec_en     = 1'b0;

    if (!start_clk_dg) begin
      state_n   = ST_IDLE;
      cken_n    = '0;
      agrst_n   = 1'b1;
      adbg_n    = 1'b1;
      degrst_n  = 1'b0;
      dedbg_n   = 1'b0;
      ch_n      = 3'd0;
      gap_n     = '0;
      cold_n    = 1'b0;
      armed_n   = 1'b0;
      dbg_win_n = 1'b0;
      ec_clr    = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cken_n  = '0;
          agrst_n = 1'b1;
          adbg_n  = 1'b1;
          state_n = ST_CKEN;
          ch_n    = 3'd0;
          gap_n   = gap_load;
        end

        ST_CKEN: begin
          // gap_cnt of 0 is treated like 1 so a slot can never stall.
          if (gap_cnt <= GAP_W'(1)) begin
            cken_n[ch_idx] = cken_mask[ch_idx];
            gap_n          = gap_load;
            if (ch_idx == CH_DDR3) begin
              state_n = ST_SETTLE;
              ec_load = 1'b1;
              cold_n  = 1'b1;
            end else begin
              ch_n = ch_idx + 3'd1;
            end
          end else begin
            gap_n = gap_cnt - GAP_W'(1);
          end
        end

        ST_SETTLE, ST_WRST: begin
          ec_en = 1'b1;
          if (ec_done) begin
            state_n  = ST_DEASSERT;
            agrst_n  = 1'b0;
            degrst_n = 1'b1;
            armed_n  = 1'b0;
            // Warm reset also asserted dbginit, so it is released as well.
            if (cold || (state == ST_WRST)) begin
              adbg_n  = 1'b0;
              dedbg_n = 1'b1;
            end
          end
        end

        ST_DEASSERT: begin
          // A sync pulse during the first window cycle is not counted.
          if (!armed) begin
            armed_n = 1'b1;
          end else if (sync_edge_dg) begin
            degrst_n = 1'b0;
            dedbg_n  = 1'b0;
            state_n  = ST_RUN;
          end
        end

        ST_RUN, ST_DBG: begin
          if (wrm_rise) begin
            // Warm reset wins over a coincident or pending debug init.
            state_n   = ST_WRST;
            agrst_n   = 1'b1;
            adbg_n    = 1'b1;
            degrst_n  = 1'b0;
            dedbg_n   = 1'b0;
            ec_load   = 1'b1;
            cold_n    = 1'b0;
            dbg_win_n = 1'b0;
          end else if (state == ST_RUN) begin
            if (dbg_rise) begin
              state_n   = ST_DBG;
              adbg_n    = 1'b1;
              dbg_win_n = 1'b0;
            end
          end else if (sync_edge_dg) begin
            if (!dbg_win) begin
              adbg_n    = 1'b0;
              dedbg_n   = 1'b1;
              dbg_win_n = 1'b1;
            end else begin
              dedbg_n   = 1'b0;
              dbg_win_n = 1'b0;
              state_n   = ST_RUN;
            end
          end
        end

        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end

    busy_n = (state_n != ST_RUN);
  end

  assign seq_state = state;

endmodule

// File: tb/tb_ctu_clsp_dramseq.sv
module tb_ctu_clsp_dramseq;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] gap = 4'd2;
  logic [5:0] mask = 6'h3F;
  logic       wrm = 1'b0;
  logic       dbg = 1'b0;
  logic [5:0] cken_dg;
  logic       a_grst, a_dbg, de_grst, de_dbg, busy;
  logic [2:0] seq_state;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  ctu_clsp_dramseq dut (
    .dram_gclk                (clk),
    .io_pwron_rst_l           (rst_n),
    .start_clk_dg             (start),
    .sync_edge_dg             (sync),
    .stagger_gap              (gap),
    .cken_mask                (mask),
    .wrm_rst_req_dg           (wrm),
    .dbginit_req_dg           (dbg),
    .cken_dg                  (cken_dg),
    .a_grst_dg                (a_grst),
    .a_dbginit_dg             (a_dbg),
    .de_grst_dsync_edge_dg    (de_grst),
    .de_dbginit_dsync_edge_dg (de_dbg),
    .seq_busy                 (busy),
    .seq_state                (seq_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Modes use the published state numbers. CKEN is modelled by elapsed
  // cycles since entry; settle/warm phases by counting sync pulses.
  int         m_mode = 0;
  int         m_t, m_g, m_edges;
  bit         m_first, m_win, m_wp, m_dp, wr, dr;
  logic [5:0] e_cken = 6'h00;
  logic       e_agrst = 1'b1, e_adbg = 1'b1, e_degrst = 1'b0, e_dedbg = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_mode = 0; e_cken = 6'h00; e_agrst = 1; e_adbg = 1; e_degrst = 0; e_dedbg = 0;
      m_wp = 0; m_dp = 0;
    end else begin
      wr = wrm && !m_wp;
      dr = dbg && !m_dp;
      m_wp = wrm;
      m_dp = dbg;
      if (!start) begin
        m_mode = 0; e_cken = 6'h00; e_agrst = 1; e_adbg = 1; e_degrst = 0; e_dedbg = 0;
      end else begin
        case (m_mode)
          0: begin
            m_mode = 1; m_t = 0; m_g = (gap == 0) ? 1 : int'(gap);
          end
          1: begin
            m_t++;
            for (int i = 0; i < 6; i++)
              if (m_t == (i + 1) * m_g) e_cken[i] = mask[i];
            if (m_t == 6 * m_g) begin m_mode = 2; m_edges = 0; end
          end
          2, 5: begin
            if (sync) begin
              m_edges++;
              if (m_edges == SETTLE) begin
                m_mode = 3; m_first = 1;
                e_agrst = 0; e_adbg = 0; e_degrst = 1; e_dedbg = 1;
              end
            end
          end
          3: begin
            if (m_first) m_first = 0;
            else if (sync) begin m_mode = 4; e_degrst = 0; e_dedbg = 0; end
          end
          4, 6: begin
            if (wr) begin
              m_mode = 5; m_edges = 0; e_agrst = 1; e_adbg = 1; e_degrst = 0; e_dedbg = 0;
            end else if (m_mode == 4) begin
              if (dr) begin m_mode = 6; m_win = 0; e_adbg = 1; end
            end else if (sync) begin
              if (!m_win) begin m_win = 1; e_adbg = 0; e_dedbg = 1; end
              else begin m_mode = 4; e_dedbg = 0; end
            end
          end
          default: m_mode = 0;
        endcase
      end
    end
  end

  // ---------------- compare (every negedge) ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_state", 8'(seq_state), 8'h00);
      chk("rst_cken",  8'(cken_dg),   8'h00);
      chk("rst_agrst", 8'(a_grst),    8'h01);
      chk("rst_adbg",  8'(a_dbg),     8'h01);
      chk("rst_de",    8'({de_grst, de_dbg}), 8'h00);
      chk("rst_busy",  8'(busy),      8'h01);
    end else begin
      chk("state",      8'(seq_state), 8'(m_mode));
      chk("cken",       8'(cken_dg),   8'(e_cken));
      chk("a_grst",     8'(a_grst),    8'(e_agrst));
      chk("a_dbginit",  8'(a_dbg),     8'(e_adbg));
      chk("de_grst",    8'(de_grst),   8'(e_degrst));
      chk("de_dbginit", 8'(de_dbg),    8'(e_dedbg));
      chk("busy",       8'(busy),      8'(m_mode != 4));
      // Hand-computed pins
      case (cyc)
        12:  chk("t1_pre_bit0", 8'(cken_dg), 8'h00);
        13:  begin chk("t1_bit0", 8'(cken_dg), 8'h01); chk("t1_st_cken", 8'(seq_state), 8'h01); end
        15:  chk("t1_bit1", 8'(cken_dg), 8'h03);
        22:  chk("t1_bit4", 8'(cken_dg), 8'h1F);
        23:  begin chk("t1_bit5", 8'(cken_dg), 8'h3F); chk("t1_settle", 8'(seq_state), 8'h02); end
        39:  begin chk("t1_pre_deas", 8'(seq_state), 8'h02); chk("t1_grst_hi", 8'(a_grst), 8'h01); end
        40:  begin
               chk("t1_win", 8'({de_grst, de_dbg}), 8'h03);
               chk("t1_a_low", 8'({a_grst, a_dbg}), 8'h00);
               chk("t1_busy", 8'(busy), 8'h01);
             end
        44:  chk("t1_win_held", 8'(de_grst), 8'h01);
        45:  begin
               chk("t1_win_clr", 8'({de_grst, de_dbg}), 8'h00);
               chk("t1_run", 8'(seq_state), 8'h04);
               chk("t1_idle_busy", 8'(busy), 8'h00);
             end
        53:  begin
               chk("t3_wrst", 8'(seq_state), 8'h05);
               chk("t3_a_hi", 8'({a_grst, a_dbg}), 8'h03);
               chk("t3_cken_held", 8'(cken_dg), 8'h3F);
             end
        70:  begin chk("t3_win", 8'({de_grst, de_dbg}), 8'h03); chk("t3_deas", 8'(seq_state), 8'h03); end
        75:  chk("t3_run", 8'(seq_state), 8'h04);
        78:  begin chk("t4_dbg", 8'(seq_state), 8'h06); chk("t4_adbg_hi", 8'(a_dbg), 8'h01); end
        79:  chk("t4_adbg_hold", 8'(a_dbg), 8'h01);
        80:  begin
               chk("t4_adbg_drop", 8'(a_dbg), 8'h00);
               chk("t4_win_only_dbg", 8'({de_grst, de_dbg}), 8'h01);
               chk("t4_grst_low", 8'(a_grst), 8'h00);
             end
        85:  begin chk("t4_run", 8'(seq_state), 8'h04); chk("t4_win_clr", 8'(de_dbg), 8'h00); end
        88:  chk("t5_both_wrst", 8'(seq_state), 8'h05);
        110: chk("t5_run", 8'(seq_state), 8'h04);
        113: chk("t5_dbg", 8'(seq_state), 8'h06);
        116: begin
               chk("t5_abort_wrst", 8'(seq_state), 8'h05);
               chk("t5_abort_grst", 8'(a_grst), 8'h01);
               chk("t5_abort_win", 8'(de_dbg), 8'h00);
             end
        140: chk("t5_run2", 8'(seq_state), 8'h04);
        143: begin
               chk("t6_idle", 8'(seq_state), 8'h00);
               chk("t6_idle_cken", 8'(cken_dg), 8'h00);
               chk("t6_idle_grst", 8'(a_grst), 8'h01);
             end
        147: chk("t2_bit0", 8'(cken_dg), 8'h01);
        148: chk("t2_bit1_masked", 8'(cken_dg), 8'h01);
        149: chk("t2_bit2", 8'(cken_dg), 8'h05);
        152: begin chk("t2_final", 8'(cken_dg), 8'h05); chk("t2_settle", 8'(seq_state), 8'h02); end
        170: chk("t2_deas", 8'(seq_state), 8'h03);
        175: chk("t2_run", 8'(seq_state), 8'h04);
        183: chk("t6_g3_bit0", 8'(cken_dg), 8'h01);
        186: chk("t6_g3_bit1", 8'(cken_dg), 8'h03);
        188: begin chk("t6_drop_idle", 8'(seq_state), 8'h00); chk("t6_drop_cken", 8'(cken_dg), 8'h00); end
        209: begin chk("t6_settle", 8'(seq_state), 8'h02); chk("t6_cken", 8'(cken_dg), 8'h3F); end
        211: chk("t6_pre_rst", 8'(seq_state), 8'h02);
        219: chk("t6_restart_bit0", 8'(cken_dg), 8'h01);
        default: ;
      endcase
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sync pulse sampled on every edge whose count is a multiple of 5.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      sync = ((cyc + 1) % 5 == 0);
    end
  end

  initial begin
    wait_cyc(3);   rst_n = 1'b1;
    // Cold boot
    wait_cyc(10);  start = 1'b1;
    // Warm reset
    wait_cyc(52);  wrm = 1'b1;
    wait_cyc(56);  wrm = 1'b0;
    // Debug init
    wait_cyc(77);  dbg = 1'b1;
    wait_cyc(82);  dbg = 1'b0;
    // Simultaneous requests
    wait_cyc(87);  wrm = 1'b1; dbg = 1'b1;
    wait_cyc(89);  wrm = 1'b0; dbg = 1'b0;
    // Warm reset aborting debug init
    wait_cyc(112); dbg = 1'b1;
    wait_cyc(115); wrm = 1'b1;
    wait_cyc(117); wrm = 1'b0; dbg = 1'b0;
    // Zero gap with a partial mask
    wait_cyc(142); start = 1'b0;
    wait_cyc(145); start = 1'b1; gap = 4'd0; mask = 6'h05;
    // start dropped mid-CKEN
    wait_cyc(176); start = 1'b0;
    wait_cyc(179); start = 1'b1; gap = 4'd3; mask = 6'h3F;
    wait_cyc(187); start = 1'b0;
    wait_cyc(190); start = 1'b1;
    // Async reset during SETTLE
    wait_cyc(212); rst_n = 1'b0;
    #1;
    chk("async_state", 8'(seq_state), 8'h00);
    chk("async_cken",  8'(cken_dg),   8'h00);
    chk("async_a",     8'({a_grst, a_dbg}), 8'h03);
    chk("async_de",    8'({de_grst, de_dbg}), 8'h00);
    chk("async_busy",  8'(busy),      8'h01);
    wait_cyc(215); rst_n = 1'b1;
    wait_cyc(230);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
